sipo_deser: RTL

Serial-in/parallel-out deserializer that sits directly downstream of the enable flip-flop stage and consumes its 1-bit Q stream. Each cycle with E high captures one bit. After WIDTH captured bits it presents a parallel word on a valid/ready output handshake. A one-word output holding register decouples bit capture from the consumer, and a sticky overrun flag reports dropped words.

---
 rtl/sipo_deser_pkg.sv | 23 ++
 rtl/sipo_deser_if.sv | 36 +++
 rtl/sipo_deser_out_buf.sv | 59 +++++
 rtl/sipo_deser.sv | 83 ++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer.
// Build option: define SIPO_PARITY_EN to append one even-parity bit to every word.
// Width macros below give a typedef-like shorthand for word and counter vectors.
`ifndef SIPO_DESER_PKG_MACROS
`define SIPO_DESER_PKG_MACROS
`define SIPO_WORD_T(w) logic [(w)-1:0]
`define SIPO_CNT_T(w)  logic [$clog2((w)+1)-1:0]
`endif

package sipo_pkg;
  // Bit-order encodings for the MSB_FIRST parameter
  localparam int MSB_FIRST_C = 1;
  localparam int LSB_FIRST_C = 0;

  // Default configuration and its counter width
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  // Counter width for an arbitrary word width (holds 0..w)
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sipo_deser_if.sv
// Bundles bit-capture inputs and the parallel valid/ready output of the deserializer.
// master: the deserializer side (drives P/P_valid); slave: the feeder/consumer side.
// parity_err is present only when SIPO_PARITY_EN is defined.
interface sipo_deser_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic                    E;
  logic                    D;
  logic                    clr;
  logic                    P_ready;
  logic [WIDTH-1:0]        P;
  logic                    P_valid;
  logic                    overrun;
  logic [cnt_w(WIDTH)-1:0] bit_cnt;
`ifdef SIPO_PARITY_EN
  logic                    parity_err;
`endif

  modport master (
    input  E, D, clr, P_ready,
`ifdef SIPO_PARITY_EN
    output parity_err,
`endif
    output P, P_valid, overrun, bit_cnt
  );

  modport slave (
    output E, D, clr, P_ready,
`ifdef SIPO_PARITY_EN
    input  parity_err,
`endif
    input  P, P_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_deser_out_buf.sv
// One-entry valid/ready holding register for completed words, with sticky overrun.
// Latency: a word offered at an edge is visible right after that edge.
// Backpressure: a word offered while full and not being drained is dropped and flags overrun.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
`ifdef SIPO_PARITY_EN
  input  logic             in_perr,
  output logic             out_perr,
`endif
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld,
  output logic             overrun
);
  logic load;

  // Load when empty or when the current word drains on this same edge
  always_comb begin
    load = in_vld && (!out_vld || out_rdy);
  end

  // Holding register: load new word, otherwise drop valid on a completed transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dat <= '0;
      out_vld <= 1'b0;
`ifdef SIPO_PARITY_EN
      out_perr <= 1'b0;
`endif
    end else if (load) begin
      out_dat <= in_dat;
      out_vld <= 1'b1;
`ifdef SIPO_PARITY_EN
      out_perr <= in_perr;
`endif
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

  // Sticky overrun: a word arrived with nowhere to go; cleared only by clr or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
    end else if (in_vld && out_vld && !out_rdy) begin
      overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: one bit per E cycle, WIDTH-bit words out on valid/ready.
// Latency: word valid right after the edge that samples its last bit (parity bit if SIPO_PARITY_EN).
// Backpressure: one-word holding buffer; words completing while it is stalled are dropped (overrun).
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = MSB_FIRST_C
) (
  input  logic          clk,
  input  logic          rst,
  sipo_deser_if.master  bus
);
  localparam int CNT_W = cnt_w(WIDTH);
`ifdef SIPO_PARITY_EN
  localparam int LAST_I = WIDTH;      // parity bit occupies the extra count
`else
  localparam int LAST_I = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

  `SIPO_WORD_T(WIDTH) sr;
  `SIPO_WORD_T(WIDTH) shifted;
  `SIPO_WORD_T(WIDTH) word;
  `SIPO_CNT_T(WIDTH)  cnt;
  logic               done;
`ifdef SIPO_PARITY_EN
  logic               perr;
`endif

  // Next shift value, completion strobe and the word handed to the output buffer
  always_comb begin
    shifted = (MSB_FIRST == MSB_FIRST_C) ? {sr[WIDTH-2:0], bus.D} : {bus.D, sr[WIDTH-1:1]};
    done    = bus.E && !bus.clr && (cnt == LAST);
`ifdef SIPO_PARITY_EN
    // At the parity edge the data bits are already all in sr; D is the parity bit
    word = sr;
    perr = ^{sr, bus.D};
`else
    word = shifted;
`endif
  end

  // Shift register and bit counter; clr wins over a simultaneous capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bus.clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bus.E) begin
`ifdef SIPO_PARITY_EN
      if (cnt != LAST) begin
        sr <= shifted;
      end
`else
      sr <= shifted;
`endif
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign bus.bit_cnt = cnt;

  sipo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clr),
    .in_vld  (done),
    .in_dat  (word),
`ifdef SIPO_PARITY_EN
    .in_perr (perr),
    .out_perr(bus.parity_err),
`endif
    .out_rdy (bus.P_ready),
    .out_dat (bus.P),
    .out_vld (bus.P_valid),
    .overrun (bus.overrun)
  );
endmodule
